mul_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the M-extension multiply ops (MUL, MULH, MULHSU, MULHU).
- Time-shares one 16x16 unsigned multiplier across four partial products, accumulates a 64-bit product, then applies the signed high-word correction.
- Sits beside the ALU in EX: the pipeline stalls on busy and takes result on done.
- Uses the same 5-bit alu_control encoding as the ALU, so decode is unchanged.

---
 rtl/mul_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle sequencer for MUL/MULH/MULHSU/MULHU: four 16x16 partial products
// accumulated into a 64-bit unsigned product, then a signed high-word correction.
module mul_seq_ctrl #(
  parameter bit EARLY_OUT = 1'b1,
  parameter int PP_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] OP_MUL    = 5'b10001;
  localparam logic [4:0] OP_MULH   = 5'b10010;
  localparam logic [4:0] OP_MULHSU = 5'b10011;
  localparam logic [4:0] OP_MULHU  = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] result_q, result_d;

  logic        is_mul;
  logic        accept;
  logic        zero_op;

  assign is_mul  = (alu_control >= OP_MUL) && (alu_control <= OP_MULHU);
  assign accept  = (state_q == S_IDLE) && start && is_mul && !flush;
  assign zero_op = (alu_in1 == 32'd0) || (alu_in2 == 32'd0);

  // Partial-product select: cnt[1] picks the a half, cnt[0] picks the b half.
  logic [PP_W-1:0]   pp_a, pp_b;
  logic [2*PP_W-1:0] pp;
  logic [6:0]        pp_sh;
  logic [63:0]       pp_ext;

  always_comb begin
    pp_a  = cnt_q[1] ? a_q[31:16] : a_q[15:0];
    pp_b  = cnt_q[0] ? b_q[31:16] : b_q[15:0];
    pp    = pp_a * pp_b;
    unique case (cnt_q)
      2'd0:    pp_sh = 7'd0;
      2'd3:    pp_sh = 7'(2 * PP_W);
      default: pp_sh = 7'(PP_W);
    endcase
    pp_ext = 64'(pp) << pp_sh;
  end

  // Signed correction of the unsigned high word, all mod 2^32.
  logic [31:0] hi_word, sub_a, sub_b, corr_res;

  always_comb begin
    hi_word = acc_q[63:32];
    sub_a   = a_q[31] ? b_q : 32'd0;
    sub_b   = b_q[31] ? a_q : 32'd0;
    unique case (op_q)
      OP_MUL:    corr_res = acc_q[31:0];
      OP_MULH:   corr_res = hi_word - sub_a - sub_b;
      OP_MULHSU: corr_res = hi_word - sub_a;
      default:   corr_res = hi_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d   = alu_in1;
          b_d   = alu_in2;
          op_d  = alu_control;
          acc_d = 64'd0;
          cnt_d = 2'd0;
          if (EARLY_OUT && zero_op) begin
            state_d  = S_DONE;
            result_d = 32'd0;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q + pp_ext;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_CORR;
      end
      S_CORR: begin
        result_d = corr_res;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything: drop to IDLE and leave all datapath state alone.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      acc_q    <= 64'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench: one instance with early-out, one without, sharing stimulus.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] alu_in1, alu_in2;
  logic        flush;
  logic        ready0, busy0, done0, ready1, busy1, done1;
  logic [31:0] result0, result1;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] MUL    = 5'b10001;
  localparam logic [4:0] MULH   = 5'b10010;
  localparam logic [4:0] MULHSU = 5'b10011;
  localparam logic [4:0] MULHU  = 5'b10100;

  mul_seq_ctrl #(.EARLY_OUT(1'b1), .PP_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .flush(flush),
    .ready(ready0), .busy(busy0), .done(done0), .result(result0));

  mul_seq_ctrl #(.EARLY_OUT(1'b0), .PP_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .flush(flush),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Accept on E0, then watch six edges: done only after E5, idle after E6.
  task automatic do_op(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    alu_control = op; alu_in1 = a; alu_in2 = b; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_e0"}, {busy0, busy1}, 2'b11);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk({tag, "_done"}, {done0, done1}, (k == 5) ? 2'b11 : 2'b00);
      if (k == 5) begin
        chk({tag, "_res0"}, result0, exp);
        chk({tag, "_res1"}, result1, exp);
      end
      if (k == 6) chk({tag, "_ready"}, {ready0, ready1, busy0, busy1}, 4'b1100);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_control = 5'd0;
    alu_in1 = 32'd0; alu_in2 = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl0", {ready0, busy0, done0}, 3'b100);
    chk("reset_ctl1", {ready1, busy1, done1}, 3'b100);
    chk("reset_res", {result0, result1}, 64'd0);
    rst_n = 1'b1;
    step();

    do_op("mulhu_max", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    chk("mulhu_acc", u1.acc_q, 64'hFFFFFFFE00000001);
    do_op("mulh_m1x2", MULH, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    do_op("mul_m1x2", MUL, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
    do_op("mulhsu", MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    do_op("mulh_min", MULH, 32'h80000000, 32'h80000000, 32'h40000000);

    // Zero operand: u0 finishes after E0, u1 takes the full path.
    alu_control = MUL; alu_in1 = 32'd0; alu_in2 = 32'h1234; start = 1'b1;
    step();
    start = 1'b0;
    chk("eo_done_e0", {done0, done1}, 2'b10);
    chk("eo_res0", result0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("eo_done", {done0, done1}, (k == 5) ? 2'b01 : 2'b00);
      if (k == 1) chk("eo_ready0", ready0, 1'b1);
      if (k == 5) chk("eo_res1", result1, 32'd0);
    end

    // Flush with cnt=2 pending.
    alu_control = MUL; alu_in1 = 32'd3; alu_in2 = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", {ready0, ready1, busy0, busy1, done0, done1}, 6'b110000);
    chk("flush_res", {result0, result1}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("flush_nodone", {done0, done1}, 2'b00);
    end
    do_op("mul_3x5", MUL, 32'd3, 32'd5, 32'd15);

    // Flush in IDLE blocks accept.
    alu_control = MULHU; alu_in1 = 32'd7; alu_in2 = 32'd9; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_blk", {ready0, ready1}, 2'b11);

    // Starts presented while busy (including DONE) are ignored.
    alu_control = MUL; alu_in1 = 32'd4; alu_in2 = 32'd6; start = 1'b1;
    step();
    alu_control = MULHU; alu_in1 = 32'hFFFFFFFF; alu_in2 = 32'hFFFFFFFF;
    for (int k = 1; k <= 5; k++) step();
    chk("busy_ign_done", {done0, done1}, 2'b11);
    chk("busy_ign_res", {result0, result1}, {32'd24, 32'd24});
    step();
    start = 1'b0;
    chk("done_no_acc", {ready0, ready1}, 2'b11);

    // Non-mul code is ignored.
    alu_control = 5'b00000; alu_in1 = 32'd1; alu_in2 = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("nonmul_ign", {ready0, ready1, busy0, busy1}, 4'b1100);
    step();
    chk("nonmul_nodone", {done0, done1}, 2'b00);

    // Async reset between edges mid-op.
    alu_control = MULHU; alu_in1 = 32'hFFFFFFFF; alu_in2 = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_ctl", {ready0, busy0, done0, ready1, busy1, done1}, 6'b100100);
    chk("areset_res", {result0, result1}, 64'd0);
    #1 rst_n = 1'b1;
    step();
    do_op("mulhu_2x3", MULHU, 32'd2, 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
